// File: rtl/frame_pkg.sv
// Shared types and constants for the frame write-port arbitration slice.
//   FRAME_W     : frame width in bits
//   frame_t     : one frame
//   IDLE_FRAME  : filler frame pattern used by the frame buffer
//   arb_state_t : arbiter run state
//   idx_width() : index width for an N-entry vector (at least 1 bit)
package frame_pkg;

  localparam int unsigned FRAME_W = 64;

  typedef logic [FRAME_W-1:0] frame_t;

  localparam frame_t IDLE_FRAME = 64'h1E00000000000000;

  typedef enum logic {
    S_OFF = 1'b0,
    S_RUN = 1'b1
  } arb_state_t;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker over NUM_SRV requesters.
//   req : request vector
//   ptr : index with highest priority this cycle
//   gnt : one-hot grant (zero when no request)
//   idx : index of the granted requester (0 when no request)
module rr_arbiter
  import frame_pkg::*;
#(
  parameter int unsigned NUM_SRV = 3,
  parameter int unsigned PTR_W   = 2
) (
  input  logic [NUM_SRV-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SRV-1:0] gnt,
  output logic [PTR_W-1:0]   idx
);

  int unsigned j;
  logic        found;

  // Scan NUM_SRV positions starting at ptr, wrapping; first request wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_SRV; i++) begin
      j = (32'(ptr) + i) % NUM_SRV;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = PTR_W'(j);
      end
    end
  end

endmodule

// File: rtl/frame_source_arbiter.sv
// Shares the frame buffer write port between one hit-data source and
// NUM_SRV service sources, with a programmable service-insertion cadence.
//   clk, reset_n              : write-side clock, async active-low reset
//   enable                    : arbitration enable (low = no new grants)
//   srv_interval              : hit frames between forced service slots (0 = service first)
//   hit_frame/valid/ready     : hit-data source handshake
//   srv_frame/valid/ready     : service sources handshake (ready one-hot or zero)
//   hit_fifo_full/srv_fifo_full : buffer back-pressure per class
//   frame_dout/_valid/_service  : registered write to the buffer (1-cycle latency)
//   hit/srv_frame_count, stall_count : wrapping status counters
module frame_source_arbiter
  import frame_pkg::*;
#(
  parameter int unsigned NUM_SRV = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic [7:0]         srv_interval,
  input  frame_t             hit_frame,
  input  logic               hit_valid,
  output logic               hit_ready,
  input  frame_t             srv_frame [NUM_SRV],
  input  logic [NUM_SRV-1:0] srv_valid,
  output logic [NUM_SRV-1:0] srv_ready,
  input  logic               hit_fifo_full,
  input  logic               srv_fifo_full,
  output frame_t             frame_dout,
  output logic               frame_dout_valid,
  output logic               frame_dout_service,
  output logic [CNT_W-1:0]   hit_frame_count,
  output logic [CNT_W-1:0]   srv_frame_count,
  output logic [CNT_W-1:0]   stall_count
);

  localparam int unsigned PTR_W = idx_width(NUM_SRV);

  arb_state_t         state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   rr_next;
  logic [7:0]         hits_since_srv;

  logic [NUM_SRV-1:0] rr_gnt;
  logic [PTR_W-1:0]   srv_idx;

  logic               srv_any;
  logic               srv_req;
  logic               hit_req;
  logic               srv_due;
  logic               run;
  logic               grant_srv;
  logic               grant_hit;
  logic               stall;

  rr_arbiter #(
    .NUM_SRV (NUM_SRV),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req (srv_valid),
    .ptr (rr_ptr),
    .gnt (rr_gnt),
    .idx (srv_idx)
  );

  // Readies gate on reset_n and enable directly so nothing is accepted while
  // in reset or in the cycle enable falls, ahead of the state register.
  always_comb begin
    srv_any   = |srv_valid;
    srv_req   = srv_any && !srv_fifo_full;
    hit_req   = hit_valid && !hit_fifo_full;
    srv_due   = (srv_interval == 8'd0) || (hits_since_srv >= srv_interval);
    run       = reset_n && enable && (state == S_RUN);
    grant_srv = run && srv_req && (srv_due || !hit_req);
    grant_hit = run && hit_req && !grant_srv;
    hit_ready = grant_hit;
    srv_ready = grant_srv ? rr_gnt : '0;
    stall     = (state == S_RUN) && !grant_srv && !grant_hit &&
                ((hit_valid && hit_fifo_full) || (srv_any && srv_fifo_full));
    if (32'(srv_idx) == NUM_SRV - 1)
      rr_next = '0;
    else
      rr_next = srv_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= S_OFF;
      rr_ptr             <= '0;
      hits_since_srv     <= '0;
      frame_dout         <= '0;
      frame_dout_valid   <= 1'b0;
      frame_dout_service <= 1'b0;
      hit_frame_count    <= '0;
      srv_frame_count    <= '0;
      stall_count        <= '0;
    end else begin
      state            <= enable ? S_RUN : S_OFF;
      frame_dout_valid <= grant_srv || grant_hit;

      if (grant_srv) begin
        frame_dout         <= srv_frame[srv_idx];
        frame_dout_service <= 1'b1;
        rr_ptr             <= rr_next;
        hits_since_srv     <= '0;
        srv_frame_count    <= srv_frame_count + 1'b1;
      end else if (grant_hit) begin
        frame_dout         <= hit_frame;
        frame_dout_service <= 1'b0;
        if (hits_since_srv != 8'hFF)
          hits_since_srv <= hits_since_srv + 8'd1;
        hit_frame_count <= hit_frame_count + 1'b1;
      end

      if (stall)
        stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_source_arbiter.sv
module tb_frame_source_arbiter;
  import frame_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [7:0]  srv_interval;
  frame_t      hit_frame;
  logic        hit_valid;
  logic        hit_ready;
  frame_t      srv_frame [3];
  logic [2:0]  srv_valid;
  logic [2:0]  srv_ready;
  logic        hit_fifo_full;
  logic        srv_fifo_full;
  frame_t      frame_dout;
  logic        frame_dout_valid;
  logic        frame_dout_service;
  logic [31:0] hit_frame_count;
  logic [31:0] srv_frame_count;
  logic [31:0] stall_count;

  int checks;
  int failures;

  frame_source_arbiter #(
    .NUM_SRV (3),
    .CNT_W   (32)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .enable             (enable),
    .srv_interval       (srv_interval),
    .hit_frame          (hit_frame),
    .hit_valid          (hit_valid),
    .hit_ready          (hit_ready),
    .srv_frame          (srv_frame),
    .srv_valid          (srv_valid),
    .srv_ready          (srv_ready),
    .hit_fifo_full      (hit_fifo_full),
    .srv_fifo_full      (srv_fifo_full),
    .frame_dout         (frame_dout),
    .frame_dout_valid   (frame_dout_valid),
    .frame_dout_service (frame_dout_service),
    .hit_frame_count    (hit_frame_count),
    .srv_frame_count    (srv_frame_count),
    .stall_count        (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    reset_n       = 1'b0;
    enable        = 1'b0;
    hit_valid     = 1'b0;
    srv_valid     = 3'b000;
    hit_fifo_full = 1'b0;
    srv_fifo_full = 1'b0;
    srv_interval  = 8'd3;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n      = 1'b0;
    enable       = 1'b0;
    hit_valid    = 1'b1;
    srv_valid    = 3'b111;
    srv_interval = 8'd3;
    hit_fifo_full = 1'b0;
    srv_fifo_full = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({hit_ready, srv_ready, frame_dout_valid} !== 5'b0) begin
      failures++;
      $display("FAIL rst_low_ready: got %b want 00000", {hit_ready, srv_ready, frame_dout_valid});
    end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({hit_ready, srv_ready} !== 4'b0) begin
      failures++;
      $display("FAIL rst_disabled_ready: got %b want 0000", {hit_ready, srv_ready});
    end
    checks++;
    if (frame_dout_valid !== 1'b0 || frame_dout !== 64'h0) begin
      failures++;
      $display("FAIL rst_dout: got v=%b d=%h want v=0 d=0", frame_dout_valid, frame_dout);
    end
    checks++;
    if (hit_frame_count !== 32'd0 || srv_frame_count !== 32'd0 || stall_count !== 32'd0) begin
      failures++;
      $display("FAIL rst_counters: got %0d %0d %0d want 0 0 0", hit_frame_count, srv_frame_count, stall_count);
    end
    enable = 1'b1;
    #1;
    checks++;
    if (hit_ready !== 1'b0) begin
      failures++;
      $display("FAIL en_same_cycle: hit_ready got %b want 0", hit_ready);
    end
    @(negedge clk);
    checks++;
    if (hit_ready !== 1'b1 || srv_ready !== 3'b000 || frame_dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL en_first_grant: got hr=%b sr=%b v=%b want 1 000 0", hit_ready, srv_ready, frame_dout_valid);
    end
    @(negedge clk);
    checks++;
    if (frame_dout_valid !== 1'b1 || frame_dout !== hit_frame || frame_dout_service !== 1'b0 ||
        hit_frame_count !== 32'd1) begin
      failures++;
      $display("FAIL en_first_out: got v=%b d=%h s=%b cnt=%0d want 1 %h 0 1",
               frame_dout_valid, frame_dout, frame_dout_service, hit_frame_count, hit_frame);
    end
  endtask

  task automatic test_cadence();
    logic [7:0] exp_srv;
    exp_srv = 8'b1000_1000;  // bit k = output k is service
    apply_reset();
    srv_interval = 8'd3;
    hit_valid    = 1'b1;
    srv_valid    = 3'b010;
    enable       = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (frame_dout_valid !== 1'b1 || frame_dout_service !== exp_srv[k] ||
          frame_dout !== (exp_srv[k] ? srv_frame[1] : hit_frame)) begin
        failures++;
        $display("FAIL cadence_out%0d: got v=%b s=%b d=%h want v=1 s=%b", k,
                 frame_dout_valid, frame_dout_service, frame_dout, exp_srv[k]);
      end
    end
    checks++;
    if (hit_frame_count !== 32'd6 || srv_frame_count !== 32'd2) begin
      failures++;
      $display("FAIL cadence_counts: got hit=%0d srv=%0d want 6 2", hit_frame_count, srv_frame_count);
    end
  endtask

  task automatic test_strict_rr();
    int         exp_idx [6];
    int         rem [3];
    logic [2:0] exp_oh;
    exp_idx = '{0, 1, 2, 0, 1, 2};
    rem     = '{2, 2, 2};
    apply_reset();
    srv_interval = 8'd0;
    hit_valid    = 1'b1;
    srv_valid    = 3'b111;
    enable       = 1'b1;
    @(negedge clk);
    for (int g = 0; g < 6; g++) begin
      exp_oh = 3'b001 << exp_idx[g];
      checks++;
      if (srv_ready !== exp_oh || hit_ready !== 1'b0) begin
        failures++;
        $display("FAIL rr_grant%0d: got sr=%b hr=%b want sr=%b hr=0", g, srv_ready, hit_ready, exp_oh);
      end
      @(posedge clk);
      #1;
      rem[exp_idx[g]]--;
      if (rem[exp_idx[g]] == 0) srv_valid[exp_idx[g]] = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (hit_ready !== 1'b1 || srv_ready !== 3'b000) begin
      failures++;
      $display("FAIL rr_hit_after: got hr=%b sr=%b want 1 000", hit_ready, srv_ready);
    end
    checks++;
    if (frame_dout !== srv_frame[2] || frame_dout_service !== 1'b1 || srv_frame_count !== 32'd6) begin
      failures++;
      $display("FAIL rr_last_out: got d=%h s=%b cnt=%0d want %h 1 6",
               frame_dout, frame_dout_service, srv_frame_count, srv_frame[2]);
    end
  endtask

  task automatic test_full();
    apply_reset();
    srv_interval  = 8'd0;
    hit_valid     = 1'b1;
    srv_valid     = 3'b001;
    srv_fifo_full = 1'b1;
    enable        = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (hit_ready !== 1'b1 || srv_ready !== 3'b000) begin
        failures++;
        $display("FAIL full_srv_hit%0d: got hr=%b sr=%b want 1 000", i, hit_ready, srv_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (hit_frame_count !== 32'd4 || srv_frame_count !== 32'd0 || stall_count !== 32'd0) begin
      failures++;
      $display("FAIL full_srv_counts: got hit=%0d srv=%0d stall=%0d want 4 0 0",
               hit_frame_count, srv_frame_count, stall_count);
    end
    hit_fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (hit_ready !== 1'b0 || srv_ready !== 3'b000) begin
        failures++;
        $display("FAIL full_both_ready%0d: got hr=%b sr=%b want 0 000", i, hit_ready, srv_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (stall_count !== 32'd5 || hit_frame_count !== 32'd4 || frame_dout_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_both_counts: got stall=%0d hit=%0d v=%b want 5 4 0",
               stall_count, hit_frame_count, frame_dout_valid);
    end
  endtask

  task automatic test_idle_filler();
    apply_reset();
    srv_interval = 8'd255;
    hit_valid    = 1'b1;
    enable       = 1'b1;
    @(negedge clk);
    repeat (3) @(negedge clk);
    hit_valid = 1'b0;
    srv_valid = 3'b100;
    #1;
    checks++;
    if (srv_ready !== 3'b100 || hit_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_srv_grant: got sr=%b hr=%b want 100 0", srv_ready, hit_ready);
    end
    @(negedge clk);
    checks++;
    if (frame_dout_service !== 1'b1 || frame_dout !== srv_frame[2]) begin
      failures++;
      $display("FAIL idle_srv_out: got s=%b d=%h want 1 %h", frame_dout_service, frame_dout, srv_frame[2]);
    end
    // With the hit run counter cleared, interval 1 lets exactly one hit through.
    srv_interval = 8'd1;
    hit_valid    = 1'b1;
    #1;
    checks++;
    if (hit_ready !== 1'b1 || srv_ready !== 3'b000) begin
      failures++;
      $display("FAIL idle_cleared_hit: got hr=%b sr=%b want 1 000", hit_ready, srv_ready);
    end
    @(negedge clk);
    checks++;
    if (srv_ready !== 3'b100 || hit_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_due_again: got sr=%b hr=%b want 100 0", srv_ready, hit_ready);
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    srv_interval = 8'd0;
    hit_valid    = 1'b1;
    srv_valid    = 3'b010;
    enable       = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (frame_dout_valid !== 1'b1 || srv_frame_count !== 32'd4) begin
      failures++;
      $display("FAIL arst_pre: got v=%b srv=%0d want 1 4", frame_dout_valid, srv_frame_count);
    end
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (frame_dout_valid !== 1'b0 || hit_ready !== 1'b0 || srv_ready !== 3'b000) begin
      failures++;
      $display("FAIL arst_drop: got v=%b hr=%b sr=%b want 0 0 000", frame_dout_valid, hit_ready, srv_ready);
    end
    checks++;
    if (hit_frame_count !== 32'd0 || srv_frame_count !== 32'd0 || stall_count !== 32'd0) begin
      failures++;
      $display("FAIL arst_counters: got %0d %0d %0d want 0 0 0", hit_frame_count, srv_frame_count, stall_count);
    end
    @(negedge clk);
    reset_n   = 1'b1;
    srv_valid = 3'b111;
    @(negedge clk);
    checks++;
    if (srv_ready !== 3'b001) begin
      failures++;
      $display("FAIL arst_rr_ptr: got sr=%b want 001", srv_ready);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b0;
    enable        = 1'b0;
    srv_interval  = 8'd3;
    hit_frame     = 64'hAAAA_0000_0000_0001;
    hit_valid     = 1'b0;
    srv_frame[0]  = 64'h5555_0000_0000_0000;
    srv_frame[1]  = 64'h5555_0000_0000_0001;
    srv_frame[2]  = 64'h5555_0000_0000_0002;
    srv_valid     = 3'b000;
    hit_fifo_full = 1'b0;
    srv_fifo_full = 1'b0;

    test_reset();
    test_cadence();
    test_strict_rr();
    test_full();
    test_idle_filler();
    test_async_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
